// File: rtl/alu_frame_tx_pkg.sv
// Shared definitions for the ALU framer egress stage.
// Holds FSM state encodings, byte-index width and the FIFO entry layout
// so the top level and the FIFO agree on word format.
package alu_frame_tx_pkg;

    localparam int WORD_W         = 32;
    localparam int BYTE_W         = 8;
    localparam int BYTES_PER_WORD = WORD_W / BYTE_W;
    localparam int BIDX_W         = 2;

    localparam logic [BIDX_W-1:0] FIRST_BYTE = BIDX_W'(0);
    localparam logic [BIDX_W-1:0] LAST_BYTE  = BIDX_W'(BYTES_PER_WORD - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } tx_state_t;

    // One FIFO slot: frame word plus its end-of-frame marker.
    typedef struct packed {
        logic              last;
        logic [WORD_W-1:0] data;
    } fifo_entry_t;

    localparam int ENTRY_W = $bits(fifo_entry_t);

    // Byte currently presented on the link: the top byte of the shift register.
    function automatic logic [BYTE_W-1:0] msb_byte(input logic [WORD_W-1:0] w);
        return w[WORD_W-1 -: BYTE_W];
    endfunction

endpackage

// File: rtl/alu_frame_tx_fifo.sv
// Purpose: DEPTH x W synchronous FIFO with occupancy count, full/empty flags.
// Latency: write visible on rd_dat the cycle after push; rd_dat is combinational from rd_ptr.
// Backpressure: push on full is refused unless a pop happens the same cycle; pop on empty ignored.
// Ports: clk, rst (sync, active-high), push/wr_dat, pop/rd_dat, count, full, empty.
module alu_frame_tx_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 33
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [W-1:0]           wr_dat,
    input  logic                   pop,
    output logic [W-1:0]           rd_dat,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);

    // A full FIFO still takes a word when a slot frees up in the same cycle.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    assign rd_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/alu_frame_tx.sv
// Purpose: egress stage of the ALU framer; buffers 32-bit words and serialises them MSB-first as bytes.
// Latency: word pushed in cycle N into an idle, empty stage appears as byte 0 in cycle N+2; words chain with no bubble.
// Backpressure: in_bp raised at DEPTH-BP_SLACK words; tx_rdy=0 freezes the byte; pushes into a full FIFO are dropped and flagged on ovf.
// Ports: clk, rst (sync, active-high); in_val/in_data/in_last/in_bp framer side;
//        tx_val/tx_data/tx_sop/tx_eop/tx_rdy link side; frame_cnt, ovf status.
module alu_frame_tx
    import alu_frame_tx_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int BP_SLACK = 2,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_val,
    input  logic [31:0]       in_data,
    input  logic              in_last,
    output logic              in_bp,
    output logic              tx_val,
    output logic [7:0]        tx_data,
    output logic              tx_sop,
    output logic              tx_eop,
    input  logic              tx_rdy,
    output logic [CNT_W-1:0]  frame_cnt,
    output logic              ovf
);

    localparam int CW = $clog2(DEPTH) + 1;

    tx_state_t         state;
    tx_state_t         state_nxt;
    logic [WORD_W-1:0] shreg;
    logic [WORD_W-1:0] shreg_nxt;
    logic              last_q;
    logic              last_nxt;
    logic [BIDX_W-1:0] byte_idx;
    logic [BIDX_W-1:0] byte_idx_nxt;
    logic              sop_pending;

    logic              pop;
    logic              xfer;
    fifo_entry_t       fifo_wr;
    fifo_entry_t       fifo_rd;
    logic [CW-1:0]     fifo_count;
    logic              fifo_full;
    logic              fifo_empty;

    assign fifo_wr.last = in_last;
    assign fifo_wr.data = in_data;

    alu_frame_tx_fifo #(
        .DEPTH (DEPTH),
        .W     (ENTRY_W)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push   (in_val),
        .wr_dat (fifo_wr),
        .pop    (pop),
        .rd_dat (fifo_rd),
        .count  (fifo_count),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    // Decoded from the registered count so the framer sees a clean flop-based level.
    assign in_bp = (fifo_count >= CW'(DEPTH - BP_SLACK));

    assign tx_val  = (state == ST_SEND);
    assign tx_data = msb_byte(shreg);
    assign tx_sop  = tx_val && (byte_idx == FIRST_BYTE) && sop_pending;
    assign tx_eop  = tx_val && (byte_idx == LAST_BYTE) && last_q;
    assign xfer    = tx_val && tx_rdy;

    always_comb begin
        state_nxt    = state;
        shreg_nxt    = shreg;
        last_nxt     = last_q;
        byte_idx_nxt = byte_idx;
        pop          = 1'b0;

        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop          = 1'b1;
                    shreg_nxt    = fifo_rd.data;
                    last_nxt     = fifo_rd.last;
                    byte_idx_nxt = FIRST_BYTE;
                    state_nxt    = ST_SEND;
                end
            end
            ST_SEND: begin
                if (xfer) begin
                    if (byte_idx == LAST_BYTE) begin
                        // Reload straight from the FIFO so back-to-back words leave no gap.
                        if (!fifo_empty) begin
                            pop          = 1'b1;
                            shreg_nxt    = fifo_rd.data;
                            last_nxt     = fifo_rd.last;
                            byte_idx_nxt = FIRST_BYTE;
                        end else begin
                            // Zeroed so tx_data rests at 0 while idle.
                            shreg_nxt    = '0;
                            last_nxt     = 1'b0;
                            byte_idx_nxt = FIRST_BYTE;
                            state_nxt    = ST_IDLE;
                        end
                    end else begin
                        shreg_nxt    = {shreg[WORD_W-BYTE_W-1:0], {BYTE_W{1'b0}}};
                        byte_idx_nxt = byte_idx + 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            shreg    <= '0;
            last_q   <= 1'b0;
            byte_idx <= FIRST_BYTE;
        end else begin
            state    <= state_nxt;
            shreg    <= shreg_nxt;
            last_q   <= last_nxt;
            byte_idx <= byte_idx_nxt;
        end
    end

    // sop_pending marks that the next word begins a new frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            sop_pending <= 1'b1;
            frame_cnt   <= '0;
            ovf         <= 1'b0;
        end else begin
            if (xfer && tx_eop) begin
                sop_pending <= 1'b1;
            end else if (xfer && tx_sop) begin
                sop_pending <= 1'b0;
            end
            if (xfer && tx_eop) begin
                frame_cnt <= frame_cnt + 1'b1;
            end
            // Same condition the FIFO uses to refuse a push.
            if (in_val && fifo_full && !pop) begin
                ovf <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_frame_tx.sv
module tb_alu_frame_tx;

    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_val;
    logic [31:0]      in_data;
    logic             in_last;
    logic             in_bp;
    logic             tx_val;
    logic [7:0]       tx_data;
    logic             tx_sop;
    logic             tx_eop;
    logic             tx_rdy;
    logic [CNT_W-1:0] frame_cnt;
    logic             ovf;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    alu_frame_tx #(
        .DEPTH    (8),
        .BP_SLACK (2),
        .CNT_W    (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_val    (in_val),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_bp     (in_bp),
        .tx_val    (tx_val),
        .tx_data   (tx_data),
        .tx_sop    (tx_sop),
        .tx_eop    (tx_eop),
        .tx_rdy    (tx_rdy),
        .frame_cnt (frame_cnt),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         c;
        logic [7:0] d;
        logic       sop;
        logic       eop;
    } beat_t;

    beat_t q[$];

    typedef struct packed {
        logic [31:0] word;
        logic        last;
        logic [31:0] exp_bytes;   // byte 0 in bits 31:24
        logic [3:0]  exp_sop;     // bit i = byte i
        logic [3:0]  exp_eop;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] byte_of(input logic [31:0] w, input int i);
        return w[31-8*i -: 8];
    endfunction

    function automatic logic [31:0] ovf_word(input int j);
        logic [7:0] b0, b1, b2, b3;
        b0 = 8'(4*j);
        b1 = 8'(4*j+1);
        b2 = 8'(4*j+2);
        b3 = 8'(4*j+3);
        return {b0, b1, b2, b3};
    endfunction

    // Link monitor: records every transfer and checks that a stalled byte is held.
    logic       hold_v = 1'b0;
    logic [9:0] hold_s;
    always @(negedge clk) begin
        if (rst) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                chk("hold", {tx_val, tx_data, tx_sop, tx_eop}, {1'b1, hold_s});
            end
            if (tx_val && tx_rdy) begin
                q.push_back('{cyc, tx_data, tx_sop, tx_eop});
            end
            hold_v = tx_val && !tx_rdy;
            hold_s = {tx_data, tx_sop, tx_eop};
        end
    end

    task automatic chk_reset_outputs(input string nm);
        chk({nm, "_val"}, tx_val, 0);
        chk({nm, "_data"}, tx_data, 0);
        chk({nm, "_sop"}, tx_sop, 0);
        chk({nm, "_eop"}, tx_eop, 0);
        chk({nm, "_bp"}, in_bp, 0);
        chk({nm, "_cnt"}, frame_cnt, 0);
        chk({nm, "_ovf"}, ovf, 0);
    endtask

    // Push table entries lo..hi on consecutive cycles and compare the byte stream.
    task automatic run_table(input int lo, input int hi, input bit toggle);
        int n;
        int t;
        n = 4 * (hi - lo + 1);
        q.delete();
        t = 0;
        while ((q.size() < n || t <= hi - lo) && t < 100) begin
            if (t <= hi - lo) begin
                in_val  = 1'b1;
                in_data = tbl[lo+t].word;
                in_last = tbl[lo+t].last;
            end else begin
                in_val  = 1'b0;
                in_last = 1'b0;
            end
            tx_rdy = toggle ? t[0] : 1'b1;
            step();
            t++;
        end
        in_val = 1'b0;
        in_last = 1'b0;
        tx_rdy = 1'b1;
        repeat (6) step();
        chk("tbl_count", q.size(), n);
        if (q.size() == n) begin
            for (int e = lo; e <= hi; e++) begin
                for (int i = 0; i < 4; i++) begin
                    beat_t b;
                    b = q[4*(e-lo)+i];
                    chk($sformatf("tbl%0d_b%0d_data", e, i), b.d, byte_of(tbl[e].exp_bytes, i));
                    chk($sformatf("tbl%0d_b%0d_sop", e, i), b.sop, tbl[e].exp_sop[i]);
                    chk($sformatf("tbl%0d_b%0d_eop", e, i), b.eop, tbl[e].exp_eop[i]);
                end
            end
            if (!toggle) begin
                for (int k = 1; k < n; k++) begin
                    chk($sformatf("tbl_nobubble%0d", k), q[k].c, q[0].c + k);
                end
            end
        end
    endtask

    initial begin
        int n0;
        int b;

        tbl[0] = '{32'h11223344, 1'b1, 32'h11223344, 4'b0001, 4'b1000};
        tbl[1] = '{32'h55667788, 1'b1, 32'h55667788, 4'b0001, 4'b1000};
        tbl[2] = '{32'h00010203, 1'b0, 32'h00010203, 4'b0001, 4'b0000};
        tbl[3] = '{32'h04050607, 1'b0, 32'h04050607, 4'b0000, 4'b0000};
        tbl[4] = '{32'h08090A0B, 1'b1, 32'h08090A0B, 4'b0000, 4'b1000};
        tbl[5] = '{32'hFF00FF00, 1'b1, 32'hFF00FF00, 4'b0001, 4'b1000};

        rst = 1'b1;
        in_val = 1'b0;
        in_data = '0;
        in_last = 1'b0;
        tx_rdy = 1'b0;
        repeat (3) step();
        @(negedge clk);
        chk_reset_outputs("rst_hold");
        step();
        rst = 1'b0;
        step();
        @(negedge clk);
        chk_reset_outputs("rst_rel");

        // Single one-word frame, exact timing N+2..N+5.
        tx_rdy = 1'b1;
        q.delete();
        step();
        n0 = cyc;
        in_val = 1'b1;
        in_data = 32'hA1B2C3D4;
        in_last = 1'b1;
        step();
        in_val = 1'b0;
        in_last = 1'b0;
        repeat (8) step();
        chk("t1_count", q.size(), 4);
        if (q.size() == 4) begin
            chk("t1_b0", q[0].d, 8'hA1);
            chk("t1_b1", q[1].d, 8'hB2);
            chk("t1_b2", q[2].d, 8'hC3);
            chk("t1_b3", q[3].d, 8'hD4);
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("t1_cyc%0d", i), q[i].c, n0 + 2 + i);
                chk($sformatf("t1_sop%0d", i), q[i].sop, i == 0);
                chk($sformatf("t1_eop%0d", i), q[i].eop, i == 3);
            end
        end
        @(negedge clk);
        chk("t1_frame_cnt", frame_cnt, 1);

        // Two back-to-back one-word frames, then a 3-word frame with stalls, then one more.
        run_table(0, 1, 1'b0);
        @(negedge clk);
        chk("t4_frame_cnt", frame_cnt, 3);
        step();
        run_table(2, 4, 1'b1);
        @(negedge clk);
        chk("t2_frame_cnt", frame_cnt, 4);
        step();
        run_table(5, 5, 1'b0);
        @(negedge clk);
        chk("t5w_frame_cnt", frame_cnt, 5);

        // Overflow: link stalled; word 0 sits in the shift register, words 1..8 fill
        // the FIFO, word 9 is the first one refused.
        tx_rdy = 1'b0;
        q.delete();
        step();
        for (int j = 0; j <= 10; j++) begin
            if (j < 10) begin
                in_val  = 1'b1;
                in_data = ovf_word(j);
                in_last = (j == 8);
            end else begin
                in_val  = 1'b0;
                in_last = 1'b0;
            end
            @(negedge clk);
            chk($sformatf("t3_bp%0d", j), in_bp, j >= 7);
            chk($sformatf("t3_ovf%0d", j), ovf, j >= 10);
            step();
        end
        in_val = 1'b0;
        tx_rdy = 1'b1;
        b = 0;
        while (q.size() < 36 && b < 100) begin
            step();
            b++;
        end
        repeat (6) step();
        chk("t3_count", q.size(), 36);
        if (q.size() == 36) begin
            for (int k = 0; k < 36; k++) begin
                chk($sformatf("t3_b%0d", k), q[k].d, k);
                chk($sformatf("t3_sop%0d", k), q[k].sop, k == 0);
                chk($sformatf("t3_eop%0d", k), q[k].eop, k == 35);
            end
        end
        @(negedge clk);
        chk("t3_ovf_sticky", ovf, 1);
        chk("t3_bp_drained", in_bp, 0);
        chk("t3_frame_cnt", frame_cnt, 6);

        // Reset during byte 2 with a second word queued behind.
        tx_rdy = 1'b1;
        step();
        in_val = 1'b1;
        in_data = 32'hDEADBEEF;
        in_last = 1'b1;
        step();
        in_data = 32'h0BADF00D;
        step();
        in_val = 1'b0;
        in_last = 1'b0;
        step();
        step();
        rst = 1'b1;
        @(negedge clk);
        chk("t5_byte2", tx_data, 8'hBE);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk_reset_outputs("t5_post");
        q.delete();
        repeat (6) step();
        chk("t5_fifo_flushed", q.size(), 0);
        in_val = 1'b1;
        in_data = 32'h5A6B7C8D;
        in_last = 1'b1;
        step();
        in_val = 1'b0;
        in_last = 1'b0;
        repeat (8) step();
        chk("t5_new_count", q.size(), 4);
        if (q.size() == 4) begin
            chk("t5_new_sop", q[0].sop, 1);
            chk("t5_new_b0", q[0].d, 8'h5A);
            chk("t5_new_eop", q[3].eop, 1);
        end
        @(negedge clk);
        chk("t5_frame_cnt", frame_cnt, 1);

        // Counter wrap: 254 more frames to reach all-ones, then one more.
        for (int i = 0; i < 254; i++) begin
            step();
            in_val = 1'b1;
            in_data = i;
            in_last = 1'b1;
            step();
            in_val = 1'b0;
            in_last = 1'b0;
            step();
            step();
        end
        repeat (10) step();
        @(negedge clk);
        chk("t6_cnt_max", frame_cnt, 8'hFF);
        step();
        in_val = 1'b1;
        in_data = 32'hCAFEF00D;
        in_last = 1'b1;
        step();
        in_val = 1'b0;
        in_last = 1'b0;
        repeat (10) step();
        @(negedge clk);
        chk("t6_cnt_wrap", frame_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
